nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Time-multiplexed controller for the 784-64-32-10 classifier.
- Runs one shared accumulator neuron by neuron and layer by layer.
- Fetches biases and weights from an external synchronous weight memory and stores hidden activations in internal buffers.
- Tracks the running argmax of the output layer; start/busy/done handshake with the system.

Parameters:
IN_SIZE, 784, binary input features (layer-1 fan-in)
H1_SIZE, 64, hidden layer 1 neurons
H2_SIZE, 32, hidden layer 2 neurons
OUT_SIZE, 10, output classes
W_WIDTH, 16, signed weight/bias/activation width
ACC_WIDTH, 40, signed accumulator width
ADDR_W, 16, weight memory address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin inference; sampled only in IDLE
features  in  IN_SIZE  input bits, latched on the edge that accepts start
busy  out  1  high from the accepting edge until done
done  out  1  one-cycle pulse, prediction valid
prediction  out  4  argmax class index, held until next done
w_rd_en  out  1  weight memory read strobe
w_addr  out  ADDR_W  weight memory word address
w_data  in  W_WIDTH  signed read data, valid the cycle after w_rd_en

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, w_rd_en=0, w_addr=0, prediction=0. Activation buffers are not cleared.
- Memory layout, flat per layer: layer1 base 0, layer2 base H1·(IN+1), layer3 base that plus H2·(H1+1).
  - Neuron n of a layer with fan-in F occupies base+n·(F+1)+k.
  - k=0 is the bias; k=1..F are weights for inputs 0..F-1.
- FSM: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH next neuron | DONE) -> IDLE.
- IDLE: start=1 latches features, sets busy, and clears layer/neuron/k counters and argmax state.
- FETCH: F+1 consecutive cycles, w_rd_en=1, w_addr = base+n·(F+1)+k with k incrementing 0..F.
- Accumulate: in the cycle after each read, acc is updated from w_data.
  - k=0: acc = sign-extended bias.
  - Layer 1: acc += w_data if features[k-1]=1, else unchanged.
  - Layers 2/3: acc += w_data × act[k-1], a full 2·W_WIDTH signed product, sign-extended.
- DRAIN: 1 cycle, w_rd_en=0; the last weight is accumulated.
- WRITE: 1 cycle.
  - Saturate acc to the signed W_WIDTH range.
  - Hidden layers: apply ReLU (negative -> 0) and write to h1[n] or h2[n].
  - Output layer: compare the saturated value with the running max.
- Neuron timing: F+3 cycles. Total latency LAT = H1·(IN+3) + H2·(H1+3) + OUT·(H2+3).
  - done pulses in cycle LAT+1 after the accepting edge (52863 cycles at defaults).
- Argmax:
  - Output neuron 0 initialises max/index.
  - Later neurons replace them only on strictly greater, so ties resolve to the lowest index.
  - prediction register updates in the DONE cycle only.
- DONE: done=1, busy drops in the same cycle, return to IDLE. start in the DONE cycle is ignored; a new start is accepted from the next cycle on.
- start while busy: ignored, no restart. features changes while busy: no effect.
- Reset mid-inference: immediate abort to the reset values above; prediction returns to 0. The next start restarts cleanly from layer 1, neuron 0.
- w_addr holds its last value when w_rd_en=0.

Test Plan:
- Small config (IN=4, H1=2, H2=2, OUT=2) -> reads at addresses 0..9 (layer 1), 10..15, 16..21 in order; done in cycle 35 after start; busy high throughout.
- All weights 0, biases (out0=5, out1=5) -> tie, prediction=0. Change out1 bias to 6 -> prediction=1.
- features=4'b0101, layer-1 weights 1..4 per neuron, bias −10 -> h1 = ReLU(−10+1+3)=0 verified via output with unit downstream weights. Bias 0 -> h1=4.
- Saturation: layer-2 products summing to 40000 -> stored 32767. Summing to −40000 -> ReLU gives 0.
- start pulsed mid-run and during the DONE cycle -> no effect, exactly one done pulse per accepted start.
- rst asserted in the middle of layer 2 -> outputs return to reset values asynchronously; the next start produces correct prediction and full LAT timing.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Time-multiplexed controller for a 3-layer fully connected classifier: one shared
// accumulator walks every neuron, streaming bias+weights from external memory.
module nn_layer_sequencer #(
   parameter int IN_SIZE   = 784,
   parameter int H1_SIZE   = 64,
   parameter int H2_SIZE   = 32,
   parameter int OUT_SIZE  = 10,
   parameter int W_WIDTH   = 16,
   parameter int ACC_WIDTH = 40,
   parameter int ADDR_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [IN_SIZE-1:0]        features,
   output logic                      busy,
   output logic                      done,
   output logic [3:0]                prediction,
   output logic                      w_rd_en,
   output logic [ADDR_W-1:0]         w_addr,
   input  logic signed [W_WIDTH-1:0] w_data
);

   localparam int KW = $clog2(IN_SIZE + 1);
   localparam int NW = $clog2(H1_SIZE + H2_SIZE + OUT_SIZE + 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

   state_t                      state;
   logic [1:0]                  layer;
   logic [NW-1:0]               n;
   logic [KW-1:0]               k;
   logic [KW-1:0]               fan_in;
   logic [NW-1:0]               n_last;

   logic                        vld_p0;
   logic [KW-1:0]               k_p0;
   logic [1:0]                  lyr_p0;
   logic [KW-1:0]               k_m1_p0;
   logic                        feat_bit_p0;
   logic signed [W_WIDTH-1:0]   act_p0;
   logic signed [2*W_WIDTH-1:0] prod_p0;

   logic signed [ACC_WIDTH-1:0] acc_p1;
   logic signed [W_WIDTH-1:0]   sat_p1;
   logic                        take_max;
   logic [3:0]                  next_idx;

   logic [IN_SIZE-1:0]          feat_q;
   logic signed [W_WIDTH-1:0]   h1 [H1_SIZE];
   logic signed [W_WIDTH-1:0]   h2 [H2_SIZE];
   logic signed [W_WIDTH-1:0]   max_q;
   logic [3:0]                  idx_q;

   function automatic logic signed [ACC_WIDTH-1:0] sext_w(input logic signed [W_WIDTH-1:0] x);
      return ACC_WIDTH'(x);
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] sext_p(input logic signed [2*W_WIDTH-1:0] x);
      return ACC_WIDTH'(x);
   endfunction

   // Clamp to the signed W_WIDTH range: any disagreement among the upper bits means overflow.
   function automatic logic signed [W_WIDTH-1:0] sat_w(input logic signed [ACC_WIDTH-1:0] x);
      logic [ACC_WIDTH-W_WIDTH:0] hi;
      hi = x[ACC_WIDTH-1:W_WIDTH-1];
      if (!hi[ACC_WIDTH-W_WIDTH] && (|hi))
         return {1'b0, {(W_WIDTH-1){1'b1}}};
      else if (hi[ACC_WIDTH-W_WIDTH] && !(&hi))
         return {1'b1, {(W_WIDTH-1){1'b0}}};
      else
         return x[W_WIDTH-1:0];
   endfunction

   function automatic logic signed [W_WIDTH-1:0] relu(input logic signed [W_WIDTH-1:0] x);
      return x[W_WIDTH-1] ? '0 : x;
   endfunction

   always_comb begin
      fan_in = KW'(H2_SIZE);
      n_last = NW'(OUT_SIZE - 1);
      case (layer)
         2'd0: begin
            fan_in = KW'(IN_SIZE);
            n_last = NW'(H1_SIZE - 1);
         end
         2'd1: begin
            fan_in = KW'(H1_SIZE);
            n_last = NW'(H2_SIZE - 1);
         end
         default: ;
      endcase
   end

   // p0: read data returns; select the matching feature bit / activation for weight k-1
   assign k_m1_p0 = k_p0 - KW'(1);

   always_comb begin
      feat_bit_p0 = 1'b0;
      for (int i = 0; i < IN_SIZE; i++)
         if (k_m1_p0 == KW'(i)) feat_bit_p0 = feat_q[i];
   end

   always_comb begin
      act_p0 = '0;
      if (lyr_p0 == 2'd1) begin
         for (int i = 0; i < H1_SIZE; i++)
            if (k_m1_p0 == KW'(i)) act_p0 = h1[i];
      end else begin
         for (int i = 0; i < H2_SIZE; i++)
            if (k_m1_p0 == KW'(i)) act_p0 = h2[i];
      end
   end

   assign prod_p0 = w_data * act_p0;

   // p1: accumulator holds the finished neuron sum during WRITE
   assign sat_p1   = sat_w(acc_p1);
   assign take_max = (n == '0) || (sat_p1 > max_q);
   assign next_idx = take_max ? 4'(n) : idx_q;

   always_ff @(posedge clk) begin
      k_p0   <= k;
      lyr_p0 <= layer;
      if (state == S_IDLE && start)
         feat_q <= features;
      if (vld_p0) begin
         if (k_p0 == '0)
            acc_p1 <= sext_w(w_data);
         else if (lyr_p0 == 2'd0) begin
            if (feat_bit_p0) acc_p1 <= acc_p1 + sext_w(w_data);
         end else
            acc_p1 <= acc_p1 + sext_p(prod_p0);
      end
      if (state == S_WRITE && layer == 2'd0) begin
         for (int i = 0; i < H1_SIZE; i++)
            if (n == NW'(i)) h1[i] <= relu(sat_p1);
      end
      if (state == S_WRITE && layer == 2'd1) begin
         for (int i = 0; i < H2_SIZE; i++)
            if (n == NW'(i)) h2[i] <= relu(sat_p1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         prediction <= '0;
         w_rd_en    <= 1'b0;
         w_addr     <= '0;
         layer      <= '0;
         n          <= '0;
         k          <= '0;
         vld_p0     <= 1'b0;
         max_q      <= '0;
         idx_q      <= '0;
      end else begin
         vld_p0 <= w_rd_en;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_FETCH;
                  busy    <= 1'b1;
                  w_rd_en <= 1'b1;
                  w_addr  <= '0;
                  layer   <= '0;
                  n       <= '0;
                  k       <= '0;
                  max_q   <= '0;
                  idx_q   <= '0;
               end
            end
            S_FETCH: begin
               if (k == fan_in) begin
                  w_rd_en <= 1'b0;
                  state   <= S_DRAIN;
               end else begin
                  k      <= k + KW'(1);
                  w_addr <= w_addr + ADDR_W'(1);
               end
            end
            S_DRAIN: state <= S_WRITE;
            S_WRITE: begin
               k <= '0;
               if (layer == 2'd2 && take_max) begin
                  max_q <= sat_p1;
                  idx_q <= 4'(n);
               end
               // Layers are packed back to back, so the next word is always w_addr+1.
               if (n == n_last && layer == 2'd2) begin
                  state      <= S_DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  prediction <= next_idx;
               end else begin
                  if (n == n_last) begin
                     layer <= layer + 2'd1;
                     n     <= '0;
                  end else
                     n <= n + NW'(1);
                  state   <= S_FETCH;
                  w_rd_en <= 1'b1;
                  w_addr  <= w_addr + ADDR_W'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer in a 4-2-2-2 configuration with a
// synchronous weight memory model; expected predictions are hand computed.
module tb_nn_layer_sequencer;
   localparam int IN = 4, H1 = 2, H2 = 2, OUT = 2, W = 16, ACC = 40, AW = 16;
   localparam int NWORDS = 22;
   localparam int LAT = H1 * (IN + 3) + H2 * (H1 + 3) + OUT * (H2 + 3);
   localparam int NVEC = 14;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [IN-1:0]       features;
   logic                busy, done, w_rd_en;
   logic [3:0]          prediction;
   logic [AW-1:0]       w_addr;
   logic signed [W-1:0] w_data;

   logic signed [W-1:0] mem [NWORDS];
   logic [AW-1:0]       rd_log [1024];
   int                  rd_cnt = 0;
   int                  total = 0;
   int                  bad = 0;
   int                  cur_vec = -1;

   typedef struct packed {
      logic [3:0]          feat;
      logic signed [15:0]  b1, w10, w11, w12, w13;
      logic signed [15:0]  b2, w2;
      logic signed [15:0]  b30, w30a, w30b;
      logic signed [15:0]  b31, w31a, w31b;
      logic [3:0]          exp_pred;
   } vec_t;

   vec_t vt [NVEC];

   nn_layer_sequencer #(
      .IN_SIZE(IN), .H1_SIZE(H1), .H2_SIZE(H2), .OUT_SIZE(OUT),
      .W_WIDTH(W), .ACC_WIDTH(ACC), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .features(features),
      .busy(busy), .done(done), .prediction(prediction),
      .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (w_rd_en) begin
         rd_log[rd_cnt[9:0]] = w_addr;
         rd_cnt = rd_cnt + 1;
         w_data <= (w_addr < AW'(NWORDS)) ? mem[w_addr[4:0]] : 16'sh7FFF;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL vec%0d %s: got %0d expected %0d", cur_vec, nm, act, exp);
      end
   endtask

   task automatic load_mem(input vec_t v);
      for (int nn = 0; nn < H1; nn++) begin
         mem[nn*5+0] = v.b1;  mem[nn*5+1] = v.w10; mem[nn*5+2] = v.w11;
         mem[nn*5+3] = v.w12; mem[nn*5+4] = v.w13;
      end
      for (int nn = 0; nn < H2; nn++) begin
         mem[10+nn*3] = v.b2; mem[11+nn*3] = v.w2; mem[12+nn*3] = v.w2;
      end
      mem[16] = v.b30; mem[17] = v.w30a; mem[18] = v.w30b;
      mem[19] = v.b31; mem[20] = v.w31a; mem[21] = v.w31b;
   endtask

   // disturb: extra start pulse + feature change mid-run, and start held in the DONE cycle
   task automatic run_vec(input vec_t v, input bit disturb);
      int cyc, base, nbad, extra;
      bit got, busy_bad;
      load_mem(v);
      base = rd_cnt;
      @(negedge clk);
      features = v.feat;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_accept", busy, 1);
      cyc = 0; got = 0; busy_bad = 0;
      while (!got && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (disturb && cyc == 10) begin
            start = 1'b1;
            features = ~v.feat;
         end
         if (disturb && cyc == 11) start = 1'b0;
         if (done) got = 1;
         else if (!busy) busy_bad = 1;
      end
      chk("done_seen", int'(got), 1);
      chk("latency", cyc + 1, LAT + 1);
      chk("busy_hold", int'(busy_bad), 0);
      chk("busy_in_done", busy, 0);
      chk("prediction", prediction, v.exp_pred);
      nbad = (rd_cnt - base != NWORDS) ? 1 : 0;
      for (int i = 0; i < NWORDS; i++)
         if (rd_log[(base + i) % 1024] != AW'(i)) nbad++;
      chk("addr_seq", nbad, 0);
      if (disturb) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("done_pulse", done, 0);
      if (disturb) begin
         extra = 0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
         end
         chk("no_restart", extra, 0);
         chk("pred_held", prediction, v.exp_pred);
      end
   endtask

   initial begin
      vt[0]  = '{4'b0000, 16'sd0,   16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,    16'sd5,     16'sd0, 16'sd0, 16'sd5,      16'sd0, 16'sd0, 4'd0};
      vt[1]  = '{4'b0000, 16'sd0,   16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,    16'sd5,     16'sd0, 16'sd0, 16'sd6,      16'sd0, 16'sd0, 4'd1};
      vt[2]  = '{4'b0101, -16'sd10, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd1,    16'sd1,     16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd1, 4'd0};
      vt[3]  = '{4'b0101, 16'sd0,   16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd1,    16'sd1,     16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd1, 4'd1};
      vt[4]  = '{4'b1010, -16'sd5,  16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd1,    16'sd1,     16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd1, 4'd1};
      vt[5]  = '{4'b1010, -16'sd6,  16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd1,    16'sd1,     16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd1, 4'd0};
      vt[6]  = '{4'b0101, -16'sd4,  16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd1,    16'sd1,     16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd1, 4'd0};
      vt[7]  = '{4'b1111, 16'sd199, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100,  -16'sd2,    16'sd0, 16'sd0, 16'sh8000,   16'sd1, 16'sd0, 4'd1};
      vt[8]  = '{4'b1111, 16'sd199, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100,  -16'sd1,    16'sd0, 16'sd0, 16'sh8000,   16'sd1, 16'sd0, 4'd0};
      vt[9]  = '{4'b1111, 16'sd199, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd100, 16'sd0,     16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd0, 4'd0};
      vt[10] = '{4'b1111, 16'sd199, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd100, -16'sd1,    16'sd0, 16'sd0, 16'sd0,      16'sd1, 16'sd0, 4'd1};
      vt[11] = '{4'b1111, 16'sd199, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100,  16'sd32766, 16'sd0, 16'sd0, 16'sd0,      16'sd2, 16'sd0, 4'd1};
      vt[12] = '{4'b1111, 16'sd199, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd100,  16'sd32767, 16'sd0, 16'sd0, 16'sd0,      16'sd2, 16'sd0, 4'd0};
      vt[13] = '{4'b0000, 16'sd0,   16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,    -16'sd7,    16'sd0, 16'sd0, -16'sd5,     16'sd0, 16'sd0, 4'd1};

      rst = 1'b0;
      start = 1'b0;
      features = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", w_rd_en, 0);
      chk("rst_addr", int'(w_addr), 0);
      chk("rst_pred", prediction, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         cur_vec = i;
         run_vec(vt[i], 1'b0);
      end

      cur_vec = 100;
      run_vec(vt[6], 1'b1);

      // Abort in the middle of layer 2, after a run that left prediction at 1.
      cur_vec = 200;
      run_vec(vt[3], 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (18) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_rd_en", w_rd_en, 0);
      chk("abort_addr", int'(w_addr), 0);
      chk("abort_pred", prediction, 0);
      @(negedge clk);
      rst = 1'b1;
      cur_vec = 201;
      run_vec(vt[3], 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
